decode_hazard_sequencer: RTL

Central stall/flush controller for the 5-stage pipeline with branches resolved in decode. It detects load-use and branch-operand hazards and sequences IF/ID and PC holds, ID/EX bubble insertion and taken-branch flushes. It also honours an external memory freeze and keeps saturating performance counters plus a stall watchdog. It sits beside the decode stage and drives PCWrite/IFIDWrite/control-mux enables in place of a purely combinational hazard unit.

---
 rtl/decode_hazard_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/decode_hazard_sequencer.sv
// decode_hazard_sequencer: stall/flush controller for a 5-stage pipeline whose
// branches resolve in decode. It detects load-use and branch-operand hazards,
// holds the PC and IF/ID, injects ID/EX bubbles, and flushes on taken branches.
// It also honours an external memory freeze, keeps saturating stall and flush
// counters, and raises a sticky watchdog flag on long hazard-stall runs.
module decode_hazard_sequencer #(
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             branch_taken,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_memread,
  input  logic             ext_freeze,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             ctrl_enable,
  output logic             pc_sel_branch,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {INIT, RUN, FREEZE} state_t;

  // The run counter saturates at STALL_LIMIT, so it only needs to hold that value.
  localparam int RUN_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

  state_t           state;
  logic [RUN_W-1:0] run_cnt;

  logic rs_ex_match, rt_ex_match, rs_mem_match, rt_mem_match;
  logic ex_match, mem_match;
  logic load_use, br_dep, hazard;
  logic evaluate, stall_evt, flush_evt, clear_evt;

  // Source/destination matching; register 0 is hard-wired and never a hazard.
  always_comb begin
    rs_ex_match  = id_uses_rs && (id_rs != 5'd0) && (id_rs == ex_rd);
    rt_ex_match  = id_uses_rt && (id_rt != 5'd0) && (id_rt == ex_rd);
    rs_mem_match = id_uses_rs && (id_rs != 5'd0) && (id_rs == mem_rd);
    rt_mem_match = id_uses_rt && (id_rt != 5'd0) && (id_rt == mem_rd);
    ex_match     = rs_ex_match || rt_ex_match;
    mem_match    = rs_mem_match || rt_mem_match;
    load_use     = ex_memread && ex_match;
    // A branch compares in ID, so it also waits on an ALU result still in EX
    // and on a load still in MEM.
    br_dep       = id_is_branch && ((ex_regwrite && ex_match) || (mem_memread && mem_match));
    hazard       = load_use || br_dep;
  end

  // Events that update counters; only RUN cycles without a freeze are evaluated.
  always_comb begin
    evaluate  = (state == RUN) && !ext_freeze;
    stall_evt = evaluate && hazard;
    flush_evt = evaluate && !hazard && id_is_branch && branch_taken;
    clear_evt = evaluate && !hazard;
  end

  // Pipeline control enables, combinational from state and the current decode inputs.
  always_comb begin
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    ctrl_enable   = 1'b0;
    pc_sel_branch = 1'b0;
    case (state)
      INIT: begin
        // Everything held off for the first cycle after reset.
      end
      RUN: begin
        if (ext_freeze) begin
          ctrl_enable = 1'b1;
        end else if (hazard) begin
          // Hold PC and IF/ID, bubble into ID/EX; a dependent branch waits here.
        end else if (id_is_branch && branch_taken) begin
          pc_write      = 1'b1;
          ifid_write    = 1'b1;
          ifid_flush    = 1'b1;
          ctrl_enable   = 1'b1;
          pc_sel_branch = 1'b1;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ctrl_enable = 1'b1;
        end
      end
      FREEZE: begin
        ctrl_enable = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Sequencer state: one INIT cycle, then RUN, with FREEZE while memory stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
    end else begin
      case (state)
        INIT:    state <= RUN;
        RUN:     state <= ext_freeze ? FREEZE : RUN;
        FREEZE:  state <= ext_freeze ? FREEZE : RUN;
        default: state <= INIT;
      endcase
    end
  end

  // Saturating performance counters for hazard stalls and taken-branch flushes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  // Watchdog: count consecutive hazard stalls; a clean RUN cycle restarts the
  // count, a freeze leaves it alone, and the timeout flag is sticky.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt       <= '0;
      stall_timeout <= 1'b0;
    end else if (stall_evt) begin
      if (run_cnt != RUN_W'(STALL_LIMIT)) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
      if (run_cnt >= RUN_W'(STALL_LIMIT - 1)) begin
        stall_timeout <= 1'b1;
      end
    end else if (clear_evt) begin
      run_cnt <= '0;
    end
  end

endmodule
